// File: rtl/i2c_dac_write_sequencer.sv
// i2c_dac_write_sequencer: drives a byte-level I2C master through one
// 4-byte DAC channel write (addr/W, command, data MSB, data LSB, STOP),
// with bounded retry on nack/timeout/watchdog and a done/dac_update pulse.
module i2c_dac_write_sequencer #(
   parameter logic [6:0]  SLAVE_ADDR   = 7'h48,
   parameter logic [3:0]  CMD_NIBBLE   = 4'h3,
   parameter logic [3:0]  MAX_RETRY    = 4'd3,
   parameter logic [19:0] ACK_WAIT_MAX = 20'd1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_ch,
   input  logic [11:0] req_value,
   output logic        m_start,
   output logic        m_stop,
   output logic        m_rw,
   output logic        m_go,
   output logic [7:0]  m_data_w,
   input  logic        m_idle,
   input  logic        m_ack,
   input  logic        m_nack,
   input  logic        m_timeout,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic        dac_update
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_ACK, ISSUE_STOP, WAIT_STOP, BACKOFF
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  idx, idx_nx;
   logic [3:0]  retry, retry_nx;
   logic [19:0] wdog, wdog_nx;
   logic [1:0]  cause, cause_nx;
   logic [1:0]  last_code, last_code_nx;
   logic        seen_low, seen_low_nx;
   logic [1:0]  ch;
   logic [11:0] value;
   logic [7:0]  cur_byte;
   logic        accept;
   logic        wd_exp;

   assign accept = (state == IDLE) && req_valid;
   assign wd_exp = (wdog == ACK_WAIT_MAX - 20'd1);
   assign m_rw   = 1'b0;

   // Byte table lookup for the current index
   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         2'd0: cur_byte = {SLAVE_ADDR, 1'b0};
         2'd1: cur_byte = {CMD_NIBBLE, 2'b00, ch};
         2'd2: cur_byte = value[11:4];
         2'd3: cur_byte = {value[3:0], 4'h0};
         default: cur_byte = 8'h00;
      endcase
   end

   // State and datapath registers; request captured only on accept
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= 2'd0;
         retry     <= 4'd0;
         wdog      <= 20'd0;
         cause     <= 2'd0;
         last_code <= 2'd0;
         seen_low  <= 1'b0;
         ch        <= 2'd0;
         value     <= 12'd0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         retry     <= retry_nx;
         wdog      <= wdog_nx;
         cause     <= cause_nx;
         last_code <= last_code_nx;
         seen_low  <= seen_low_nx;
         if (accept) begin
            ch    <= req_ch;
            value <= req_value;
         end
      end
   end

   // Next-state and command/status outputs
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      retry_nx     = retry;
      wdog_nx      = wdog;
      cause_nx     = cause;
      last_code_nx = last_code;
      seen_low_nx  = seen_low;
      req_ready    = 1'b0;
      busy         = 1'b1;
      m_go         = 1'b0;
      m_start      = 1'b0;
      m_stop       = 1'b0;
      m_data_w     = 8'h00;
      done         = 1'b0;
      dac_update   = 1'b0;
      error        = 1'b0;
      err_code     = last_code;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_nx = ISSUE;
               idx_nx   = 2'd0;
            end
         end
         ISSUE: begin
            m_data_w = cur_byte;
            if (m_idle) begin
               m_go     = 1'b1;
               m_start  = (idx == 2'd0);
               wdog_nx  = 20'd0;
               state_nx = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // master shifts data_w serially, so keep it stable until status
            m_data_w = cur_byte;
            wdog_nx  = wdog + 20'd1;
            if (m_timeout) begin
               cause_nx = 2'd2;
               state_nx = BACKOFF;
            end else if (m_nack) begin
               cause_nx = 2'd1;
               state_nx = BACKOFF;
            end else if (m_ack) begin
               if (idx == 2'd3) begin
                  state_nx = ISSUE_STOP;
               end else begin
                  idx_nx   = idx + 2'd1;
                  state_nx = ISSUE;
               end
            end else if (wd_exp) begin
               cause_nx = 2'd3;
               state_nx = BACKOFF;
            end
         end
         ISSUE_STOP: begin
            if (m_idle) begin
               m_go        = 1'b1;
               m_stop      = 1'b1;
               wdog_nx     = 20'd0;
               seen_low_nx = 1'b0;
               state_nx    = WAIT_STOP;
            end
         end
         WAIT_STOP: begin
            // completion needs the master to leave idle and come back
            wdog_nx = wdog + 20'd1;
            if (!m_idle) seen_low_nx = 1'b1;
            if (m_timeout) begin
               cause_nx = 2'd2;
               state_nx = BACKOFF;
            end else if (seen_low && m_idle) begin
               done       = 1'b1;
               dac_update = 1'b1;
               retry_nx   = 4'd0;
               state_nx   = IDLE;
            end else if (wd_exp) begin
               cause_nx = 2'd3;
               state_nx = BACKOFF;
            end
         end
         BACKOFF: begin
            if (m_idle) begin
               if (retry < MAX_RETRY) begin
                  retry_nx = retry + 4'd1;
                  idx_nx   = 2'd0;
                  state_nx = ISSUE;
               end else begin
                  error        = 1'b1;
                  err_code     = cause;
                  last_code_nx = cause;
                  retry_nx     = 4'd0;
                  state_nx     = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_dac_write_sequencer.sv
// Bench for i2c_dac_write_sequencer: a small I2C-master model answers each
// go with a scripted ack/nack/timeout/silence; expected byte gos and
// transaction outcomes are queued by the stimulus and popped as they occur.
module tb_i2c_dac_write_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_ch;
   logic [11:0] req_value;
   logic        m_start, m_stop, m_rw, m_go;
   logic [7:0]  m_data_w;
   logic        m_idle = 1'b1;
   logic        m_ack = 1'b0, m_nack = 1'b0, m_timeout = 1'b0;
   logic        busy, done, error, dac_update;
   logic [1:0]  err_code;

   int cmps = 0;
   int errs = 0;

   logic [10:0] exp_go[$];   // {rw, start, stop, data}
   logic [1:0]  resp_q[$];   // 0 ack, 1 nack, 2 timeout, 3 silence
   logic [3:0]  exp_out[$];  // {done, error, code}

   i2c_dac_write_sequencer #(.ACK_WAIT_MAX(20'd100)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ch(req_ch), .req_value(req_value),
      .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_go(m_go),
      .m_data_w(m_data_w), .m_idle(m_idle), .m_ack(m_ack),
      .m_nack(m_nack), .m_timeout(m_timeout),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .dac_update(dac_update)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dbyte(input logic [1:0] ch, input logic [11:0] v, input int i);
      case (i)
         0: return 8'h90;
         1: return {4'h3, 2'b00, ch};
         2: return v[11:4];
         default: return {v[3:0], 4'h0};
      endcase
   endfunction

   task automatic push_attempt(input logic [1:0] ch, input logic [11:0] v, input int n);
      for (int i = 0; i < n; i++)
         exp_go.push_back({1'b0, (i == 0), 1'b0, dbyte(ch, v, i)});
   endtask

   task automatic push_stop();
      exp_go.push_back({1'b0, 1'b0, 1'b1, 8'h00});
   endtask

   // master model: sample go at the edge, answer 3 cycles later
   logic        go_s, idle_s;
   logic [10:0] go_obs;
   logic [7:0]  held_byte;
   logic [1:0]  pend;
   int          cnt = 0;
   always @(posedge clock) begin
      go_s   = m_go;
      idle_s = m_idle;
      go_obs = {m_rw, m_start, m_stop, (m_stop ? 8'h00 : m_data_w)};
      #1;
      m_ack = 1'b0; m_nack = 1'b0; m_timeout = 1'b0;
      if (reset) begin
         cnt    = 0;
         m_idle = 1'b1;
      end else if (cnt != 0) begin
         cnt--;
         if (cnt == 0) begin
            m_idle = 1'b1;
            if (pend != 2'd3) chk("data_hold", 32'(m_data_w), 32'(held_byte));
            case (pend)
               2'd0: m_ack = 1'b1;
               2'd1: m_nack = 1'b1;
               2'd2: m_timeout = 1'b1;
               default: ;
            endcase
         end
      end else if (go_s) begin
         chk("go_while_idle", 32'(idle_s), 32'd1);
         chk("go_expected", 32'(exp_go.size() > 0), 32'd1);
         if (exp_go.size() > 0) chk("go_byte", 32'(go_obs), 32'(exp_go.pop_front()));
         held_byte = go_obs[7:0];
         m_idle = 1'b0;
         cnt = 3;
         if (go_obs[8]) pend = 2'd3;
         else if (resp_q.size() > 0) pend = resp_q.pop_front();
         else pend = 2'd0;
      end
   end

   // outcome monitor
   logic [3:0] out_exp;
   always @(negedge clock) begin
      if (!reset && (done || error || dac_update)) begin
         chk("dac_update_eq_done", 32'(dac_update), 32'(done));
         chk("outcome_expected", 32'(exp_out.size() > 0), 32'd1);
         if (exp_out.size() > 0) begin
            out_exp = exp_out.pop_front();
            chk("outcome", 32'({done, error, (error ? err_code : 2'b00)}), 32'(out_exp));
         end
      end
   end

   task automatic do_req(input logic [1:0] ch, input logic [11:0] v);
      @(negedge clock);
      chk("ready_in_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_ch = ch; req_value = v;
      @(posedge clock); #1;
      req_valid = 1'b0; req_ch = ~ch; req_value = ~v;   // must be ignored
      chk("ready_drops", 32'(req_ready), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic wait_out(input string tag, input int budget, input logic is_err, input logic [1:0] code);
      int k;
      k = 0;
      while (exp_out.size() != 0 && k < budget) begin
         @(negedge clock); #1;
         k++;
      end
      chk({tag, "_finished"}, 32'(exp_out.size()), 32'd0);
      chk({tag, "_gos_consumed"}, 32'(exp_go.size()), 32'd0);
      exp_out.delete(); exp_go.delete(); resp_q.delete();
      @(negedge clock);
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      chk({tag, "_single_pulse"}, 32'({done, dac_update, error}), 32'd0);
      if (is_err) chk({tag, "_err_code_held"}, 32'(err_code), 32'(code));
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_ch = 2'd0; req_value = 12'd0;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_outs", 32'({busy, m_go, m_start, m_stop, m_rw, done, error, dac_update}), 32'd0);
      chk("rst_data", 32'({m_data_w, err_code}), 32'd0);
      @(posedge clock); @(negedge clock);
      reset = 1'b0;

      // happy path
      exp_go.push_back({1'b0, 1'b1, 1'b0, 8'h90});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'h32});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'hAB});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'hC0});
      push_stop();
      exp_out.push_back(4'b1000);
      do_req(2'd2, 12'hABC);
      wait_out("happy", 500, 1'b0, 2'd0);

      // nack on command byte once, then success
      resp_q = {2'd0, 2'd1};
      push_attempt(2'd1, 12'h5A3, 2);
      push_attempt(2'd1, 12'h5A3, 4);
      push_stop();
      exp_out.push_back(4'b1000);
      do_req(2'd1, 12'h5A3);
      wait_out("nack_b1", 500, 1'b0, 2'd0);

      // persistent nack on address: 4 attempts, error code 1
      resp_q = {2'd1, 2'd1, 2'd1, 2'd1};
      for (int a = 0; a < 4; a++) push_attempt(2'd0, 12'h111, 1);
      exp_out.push_back(4'b0101);
      do_req(2'd0, 12'h111);
      wait_out("nack_addr", 500, 1'b1, 2'd1);

      // master timeout on data MSB, then success
      resp_q = {2'd0, 2'd0, 2'd2};
      push_attempt(2'd3, 12'hF0F, 3);
      push_attempt(2'd3, 12'hF0F, 4);
      push_stop();
      exp_out.push_back(4'b1000);
      do_req(2'd3, 12'hF0F);
      wait_out("timeout_b2", 500, 1'b0, 2'd0);

      // silent slave: watchdog on every attempt, error code 3
      resp_q = {2'd3, 2'd3, 2'd3, 2'd3};
      for (int a = 0; a < 4; a++) push_attempt(2'd2, 12'h777, 1);
      exp_out.push_back(4'b0111);
      do_req(2'd2, 12'h777);
      wait_out("watchdog", 2000, 1'b1, 2'd3);

      // reset while waiting for ack on data MSB
      resp_q = {2'd0, 2'd0, 2'd3};
      push_attempt(2'd0, 12'h5A5, 3);
      do_req(2'd0, 12'h5A5);
      for (int k = 0; k < 200 && exp_go.size() != 0; k++) @(negedge clock);
      chk("rst_mid_reached_b2", 32'(exp_go.size()), 32'd0);
      repeat (5) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_outs", 32'({busy, m_go, m_start, m_stop, done, error, dac_update}), 32'd0);
      chk("rst_mid_data", 32'(m_data_w), 32'd0);
      chk("rst_mid_errcode", 32'(err_code), 32'd0);
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      resp_q.delete(); exp_go.delete(); exp_out.delete();

      // clean request after reset
      exp_go.push_back({1'b0, 1'b1, 1'b0, 8'h90});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'h31});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'h12});
      exp_go.push_back({1'b0, 1'b0, 1'b0, 8'h30});
      push_stop();
      exp_out.push_back(4'b1000);
      do_req(2'd1, 12'h123);
      wait_out("after_reset", 500, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
